ysyx_axi_sram: RTL
==================

# ysyx_axi_sram

AXI4 slave responder backed by a synchronous word-addressed memory array; it is the far end of the core's `io_master_*` AXI4 port in standalone/NPC simulation builds. It accepts AR/AW/W, returns R/B with configurable read latency, and supports FIXED, INCR and WRAP bursts with byte strobes. Read and write channels run independent state machines that share one memory array.

## Interface
- `ADDR_W`, 32, address width (matches `YSYX_W_WIDTH`).
- `DATA_W`, 64, data bus width; fixed at 64 for this block.
- `BASE_ADDR`, 32'h8000_0000, first mapped byte address.
- `MEM_WORDS`, 4096, depth in 64-bit words; power of two.
- `R_LAT`, 1, extra cycles between AR handshake and first R beat (0..15).

Ports:
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `arid` in 4, `araddr` in ADDR_W, `arlen` in 8, `arsize` in 3, `arburst` in 2, `arvalid` in 1, `arready` out 1.
- `rid` out 4, `rdata` out 64, `rresp` out 2, `rlast` out 1, `rvalid` out 1, `rready` in 1.
- `awid` in 4, `awaddr` in ADDR_W, `awlen` in 8, `awsize` in 3, `awburst` in 2, `awvalid` in 1, `awready` out 1.
- `wdata` in 64, `wstrb` in 8, `wlast` in 1, `wvalid` in 1, `wready` out 1.
- `bid` out 4, `bresp` out 2, `bvalid` out 1, `bready` in 1.

## Operation
- Read FSM states: R_IDLE, R_WAIT, R_DATA.
  - R_IDLE to R_WAIT (or to R_DATA if `R_LAT`=0) on `arvalid & arready`. On this handshake, latch id, addr, len, size and burst, and load the beat counter with `arlen`.
  - R_WAIT counts down `R_LAT` cycles, then moves to R_DATA.
  - R_DATA holds `rvalid`=1. On `rvalid & rready`, advance the address and decrement the counter. The beat with counter==0 drives `rlast`=1; its handshake returns the FSM to R_IDLE.
- Write FSM states: W_IDLE, W_DATA, W_RESP.
  - W_IDLE to W_DATA on `awvalid & awready`.
  - In W_DATA, each `wvalid & wready` writes the bytes enabled by `wstrb` and advances the address.
  - After beat `awlen`+1 the FSM moves to W_RESP and holds `bvalid`=1 until `bready`, then returns to W_IDLE.
- `arready` = (state==R_IDLE). `awready` = (state==W_IDLE). `wready` = (state==W_DATA). All three are 0 during reset.
- Word index = (addr − BASE_ADDR) >> 3. `rdata` is the full aligned 64-bit word; the master extracts the lanes it needs.
- Next address is computed per beat from the current address and `(1<<size)`:
  - FIXED (00): unchanged.
  - INCR (01): addr + (1<<size).
  - WRAP (10): wraps within a (len+1)·(1<<size) aligned window.
  - Reserved (11): treated as INCR with resp SLVERR.
- Address arithmetic is ADDR_W-bit modulo.
- Error rules:
  - A beat whose address falls outside [BASE_ADDR, BASE_ADDR+8·MEM_WORDS) gets SLVERR (2'b10). Reads return 0 and writes are dropped.
  - `bresp` is SLVERR if any beat in the burst erred.
  - A `wlast` mismatch (asserted early, or missing on the counted last beat) sets `bresp`=SLVERR. The burst length is always governed by `awlen`.
  - WRAP with len ∉ {1,3,7,15} gives SLVERR; the burst is still served as INCR.
- A read and a write to the same word in the same cycle: the read returns the old data and the write lands at that clock edge.
- A memory write is visible to any R beat sampled on a later edge.

## Timing
- AR handshake at edge T: first `rvalid` is registered high after edge T+1+R_LAT. With rready held high, subsequent beats follow one per cycle.
- `rdata`/`rresp`/`rlast` hold stable while `rvalid & !rready`.
- The last W handshake at edge T gives `bvalid` high from T+1.
- Minimum idle gap between bursts on the same channel: 1 cycle (the IDLE state).
- Reset values: `rvalid`=0, `bvalid`=0, `rlast`=0, `rdata`=0, `rresp`=0, `bresp`=0, `rid`=0, `bid`=0. FSMs return to R_IDLE and W_IDLE.
- Reset mid-burst aborts the burst with no response. Memory contents are retained and not cleared.

## Structure
- Shared package `ysyx_axi_pkg`:
  - burst encodings FIXED/INCR/WRAP;
  - resp constants OKAY/SLVERR/DECERR;
  - read/write FSM state typedefs.
- One sub-module, `ysyx_axi_burst_addr`: combinational next-address and WRAP-legality calculator. It is instantiated once per channel.
- The memory array is an inferred register array inside this block. Its initial contents are loaded through the existing DPI-C hooks.

## Test plan
- Single read at 0x8000_0000, len=0, size=3, R_LAT=1: rvalid appears 2 cycles after the AR handshake, with rlast=1 and rresp=OKAY.
- INCR write, len=3, size=3 at 0x8000_0010, wstrb=0xFF, data 1..4, then INCR read back: returns 1,2,3,4, rlast only on beat 4, and bresp=OKAY.
- WRAP read, len=3, size=3 at 0x8000_0018: beat addresses are 0x18, 0x00, 0x08, 0x10.
- Write at 0x7FFF_FFF8: bresp=SLVERR and memory unchanged. Read at the same address: rdata=0 and rresp=SLVERR.
- Strobe and backpressure: write wstrb=0x0F over a word holding 0xAAAA…; rready toggled every other cycle during a 4-beat read. Requirements: word becomes 0xAAAAAAAA_<new low 32>; rdata stable while stalled; no beat lost or duplicated.
- Reset asserted during beat 2 of a 4-beat read: all valids 0 on the next cycle, arready=1 after reset deasserts, and a prior write is still readable.

Source files
------------

// File: rtl/ysyx_axi_pkg.sv
// ysyx_axi_pkg: shared AXI4 encodings for the SRAM responder.
//   - burst type encodings (FIXED / INCR / WRAP / reserved)
//   - response codes (OKAY / SLVERR / DECERR)
//   - read and write channel FSM state types
package ysyx_axi_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_DATA
    } r_state_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } w_state_e;

endpackage

// File: rtl/ysyx_axi_sram_if.sv
// ysyx_axi_sram_if: AXI4 bus bundle between the core's io_master port and
// the SRAM responder (64-bit data, 4-bit ids).
//   master modport: drives AR/AW/W and rready/bready.
//   slave modport : drives R/B and arready/awready/wready.
interface ysyx_axi_sram_if #(
    parameter int ADDR_W = 32
);
    logic [3:0]        arid;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              arvalid;
    logic              arready;

    logic [3:0]        rid;
    logic [63:0]       rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;

    logic [3:0]        awid;
    logic [ADDR_W-1:0] awaddr;
    logic [7:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;
    logic              awvalid;
    logic              awready;

    logic [63:0]       wdata;
    logic [7:0]        wstrb;
    logic              wlast;
    logic              wvalid;
    logic              wready;

    logic [3:0]        bid;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );

endinterface

// File: rtl/ysyx_axi_burst_addr.sv
// ysyx_axi_burst_addr: combinational AXI4 next-beat address calculator.
//   addr_i  : current beat address
//   len_i   : AxLEN (beats - 1)
//   size_i  : AxSIZE (bytes per beat = 1 << size)
//   burst_i : AxBURST
//   next_o  : address of the following beat (ADDR_W-bit modulo)
//   err_o   : burst type is reserved, or WRAP with an illegal length
module ysyx_axi_burst_addr
    import ysyx_axi_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [7:0]        len_i,
    input  logic [2:0]        size_i,
    input  logic [1:0]        burst_i,
    output logic [ADDR_W-1:0] next_o,
    output logic              err_o
);

    logic [ADDR_W-1:0] step;
    logic [ADDR_W-1:0] incr_addr;
    logic [ADDR_W-1:0] wrap_mask;
    logic              wrap_ok;

    always_comb begin
        step      = ADDR_W'(1) << size_i;
        incr_addr = addr_i + step;
        wrap_ok   = (len_i == 8'd1) || (len_i == 8'd3) ||
                    (len_i == 8'd7) || (len_i == 8'd15);
        // Window is (len+1) beats of (1<<size) bytes, aligned to its own size.
        wrap_mask = ((ADDR_W'(len_i) + ADDR_W'(1)) << size_i) - ADDR_W'(1);
        next_o    = incr_addr;
        err_o     = 1'b0;
        case (burst_i)
            BURST_FIXED: next_o = addr_i;
            BURST_INCR:  next_o = incr_addr;
            BURST_WRAP: begin
                if (wrap_ok) begin
                    next_o = (addr_i & ~wrap_mask) | (incr_addr & wrap_mask);
                end else begin
                    err_o = 1'b1;
                end
            end
            default:     err_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/ysyx_axi_sram.sv
// ysyx_axi_sram: AXI4 slave backed by a word-addressed 64-bit memory array.
//   clk : single clock
//   rst : synchronous active-high reset (memory contents are kept)
//   bus : slave side of the AXI4 bundle (AR/R/AW/W/B channels)
// Read and write channels run independent FSMs sharing one array. A read
// sampled on the same edge as a write to the same word returns old data.
module ysyx_axi_sram
    import ysyx_axi_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 64,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000,
    parameter int                MEM_WORDS = 4096,
    parameter int                R_LAT     = 1
) (
    input  logic             clk,
    input  logic             rst,
    ysyx_axi_sram_if.slave   bus
);

    localparam int                IDX_W     = $clog2(MEM_WORDS);
    localparam logic [ADDR_W-1:0] MEM_BYTES = ADDR_W'(MEM_WORDS * 8);
    localparam logic [3:0]        WAIT_INIT = 4'((R_LAT > 0) ? R_LAT - 1 : 0);

    logic [DATA_W-1:0] mem [MEM_WORDS];

    // ---------------- read channel ----------------
    r_state_e          r_state_q;
    logic [3:0]        rid_q;
    logic [ADDR_W-1:0] raddr_q;
    logic [7:0]        rlen_q, rcnt_q;
    logic [2:0]        rsize_q;
    logic [1:0]        rburst_q;
    logic [3:0]        rwait_q;
    logic              rvalid_q, rlast_q;
    logic [63:0]       rdata_q;
    logic [1:0]        rresp_q;

    logic [ADDR_W-1:0] r_next;
    logic              r_berr;
    logic [ADDR_W-1:0] r_fetch_addr, r_off;
    logic              r_fetch_ok;
    logic [63:0]       r_fetch_data;

    ysyx_axi_burst_addr #(.ADDR_W(ADDR_W)) u_rd_addr (
        .addr_i  (raddr_q),
        .len_i   (rlen_q),
        .size_i  (rsize_q),
        .burst_i (rburst_q),
        .next_o  (r_next),
        .err_o   (r_berr)
    );

    // The first beat fetches the latched address; each accepted beat
    // fetches the following one on the same edge, giving one beat per cycle.
    always_comb begin
        r_fetch_addr = (rvalid_q && bus.rready) ? r_next : raddr_q;
        r_off        = r_fetch_addr - BASE_ADDR;
        r_fetch_ok   = r_off < MEM_BYTES;
        r_fetch_data = r_fetch_ok ? mem[r_off[3 +: IDX_W]] : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= R_IDLE;
            rid_q     <= '0;
            raddr_q   <= '0;
            rlen_q    <= '0;
            rcnt_q    <= '0;
            rsize_q   <= '0;
            rburst_q  <= '0;
            rwait_q   <= '0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            case (r_state_q)
                R_IDLE: begin
                    if (bus.arvalid) begin
                        rid_q     <= bus.arid;
                        raddr_q   <= bus.araddr;
                        rlen_q    <= bus.arlen;
                        rcnt_q    <= bus.arlen;
                        rsize_q   <= bus.arsize;
                        rburst_q  <= bus.arburst;
                        rwait_q   <= WAIT_INIT;
                        r_state_q <= (R_LAT == 0) ? R_DATA : R_WAIT;
                    end
                end
                R_WAIT: begin
                    if (rwait_q == 4'd0) begin
                        r_state_q <= R_DATA;
                    end else begin
                        rwait_q <= rwait_q - 4'd1;
                    end
                end
                R_DATA: begin
                    if (!rvalid_q) begin
                        rvalid_q <= 1'b1;
                        rdata_q  <= r_fetch_data;
                        rresp_q  <= (r_fetch_ok && !r_berr) ? RESP_OKAY : RESP_SLVERR;
                        rlast_q  <= (rcnt_q == 8'd0);
                    end else if (bus.rready) begin
                        if (rcnt_q == 8'd0) begin
                            rvalid_q  <= 1'b0;
                            rlast_q   <= 1'b0;
                            r_state_q <= R_IDLE;
                        end else begin
                            raddr_q <= r_next;
                            rcnt_q  <= rcnt_q - 8'd1;
                            rdata_q <= r_fetch_data;
                            rresp_q <= (r_fetch_ok && !r_berr) ? RESP_OKAY : RESP_SLVERR;
                            rlast_q <= (rcnt_q == 8'd1);
                        end
                    end
                end
                default: r_state_q <= R_IDLE;
            endcase
        end
    end

    // ---------------- write channel ----------------
    w_state_e          w_state_q;
    logic [3:0]        bid_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [7:0]        wlen_q, wcnt_q;
    logic [2:0]        wsize_q;
    logic [1:0]        wburst_q;
    logic              werr_q;
    logic              bvalid_q;
    logic [1:0]        bresp_q;

    logic [ADDR_W-1:0] w_next, w_off;
    logic              w_berr, w_ok, w_hs, w_beat_err;

    ysyx_axi_burst_addr #(.ADDR_W(ADDR_W)) u_wr_addr (
        .addr_i  (waddr_q),
        .len_i   (wlen_q),
        .size_i  (wsize_q),
        .burst_i (wburst_q),
        .next_o  (w_next),
        .err_o   (w_berr)
    );

    always_comb begin
        w_hs       = (w_state_q == W_DATA) && bus.wvalid && !rst;
        w_off      = waddr_q - BASE_ADDR;
        w_ok       = w_off < MEM_BYTES;
        // wlast must coincide exactly with the beat counted by awlen.
        w_beat_err = !w_ok || w_berr || (bus.wlast != (wcnt_q == 8'd0));
    end

    always_ff @(posedge clk) begin
        if (w_hs && w_ok) begin
            for (int unsigned b = 0; b < DATA_W / 8; b++) begin
                if (bus.wstrb[b]) begin
                    mem[w_off[3 +: IDX_W]][8*b +: 8] <= bus.wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_q <= W_IDLE;
            bid_q     <= '0;
            waddr_q   <= '0;
            wlen_q    <= '0;
            wcnt_q    <= '0;
            wsize_q   <= '0;
            wburst_q  <= '0;
            werr_q    <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            case (w_state_q)
                W_IDLE: begin
                    if (bus.awvalid) begin
                        bid_q     <= bus.awid;
                        waddr_q   <= bus.awaddr;
                        wlen_q    <= bus.awlen;
                        wcnt_q    <= bus.awlen;
                        wsize_q   <= bus.awsize;
                        wburst_q  <= bus.awburst;
                        werr_q    <= 1'b0;
                        w_state_q <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (bus.wvalid) begin
                        if (wcnt_q == 8'd0) begin
                            bvalid_q  <= 1'b1;
                            bresp_q   <= (werr_q || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
                            w_state_q <= W_RESP;
                        end else begin
                            werr_q  <= werr_q || w_beat_err;
                            waddr_q <= w_next;
                            wcnt_q  <= wcnt_q - 8'd1;
                        end
                    end
                end
                W_RESP: begin
                    if (bus.bready) begin
                        bvalid_q  <= 1'b0;
                        w_state_q <= W_IDLE;
                    end
                end
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    assign bus.arready = (r_state_q == R_IDLE) && !rst;
    assign bus.awready = (w_state_q == W_IDLE) && !rst;
    assign bus.wready  = (w_state_q == W_DATA) && !rst;
    assign bus.rid     = rid_q;
    assign bus.rdata   = rdata_q;
    assign bus.rresp   = rresp_q;
    assign bus.rlast   = rlast_q;
    assign bus.rvalid  = rvalid_q;
    assign bus.bid     = bid_q;
    assign bus.bresp   = bresp_q;
    assign bus.bvalid  = bvalid_q;

endmodule
